// File: rtl/bram_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency BRAM between the IF fetch
// and LS load/store requesters. LS has priority; a starvation counter lets IF through.
module bram_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_wstrb,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              stall_if,
  output logic              stall_ls
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t      resp_owner_q, resp_owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic if_req_m;
  logic ls_req_m;
  logic if_wins;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr, ls_addr};

  // Arbitration: requests are masked while reset is asserted.
  always_comb begin
    if_req_m = if_req & rstn;
    ls_req_m = ls_req & rstn;
    if_wins  = (starve_cnt_q == LIMIT);
    ls_gnt   = ls_req_m & (~if_req_m | ~if_wins);
    if_gnt   = if_req_m & (~ls_req_m | if_wins);
    stall_if = if_req_m & ~if_gnt;
    stall_ls = ls_req_m & ~ls_gnt;
  end

  // BRAM port drive for the granted requester.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 4'b0000;
    bram_addr  = '0;
    bram_wdata = '0;
    if (ls_gnt) begin
      bram_en   = 1'b1;
      bram_addr = ls_addr[ADDR_W+1:2];
      if (ls_we) begin
        bram_we    = ls_wstrb;
        bram_wdata = ls_wdata;
      end
    end else if (if_gnt) begin
      bram_en   = 1'b1;
      bram_addr = if_addr[ADDR_W+1:2];
    end
  end

  // Next-state: starvation counter and response owner.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_m || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // A fetch flushed in its grant cycle is recorded as ownerless so its data is dropped.
    resp_owner_d = OWN_NONE;
    if (ls_gnt && !ls_we) begin
      resp_owner_d = OWN_LS;
    end else if (if_gnt && !if_flush) begin
      resp_owner_d = OWN_IF;
    end
  end

  // Response cycle: data bypasses straight from the BRAM and is captured for holding.
  always_comb begin
    if_rvalid  = (resp_owner_q == OWN_IF) && !if_flush;
    ls_rvalid  = (resp_owner_q == OWN_LS);
    if_rdata_d = if_rvalid ? bram_rdata : if_rdata_q;
    ls_rdata_d = ls_rvalid ? bram_rdata : ls_rdata_q;
    if_rdata   = if_rdata_d;
    ls_rdata   = ls_rdata_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt_q <= 4'd0;
      resp_owner_q <= OWN_NONE;
      if_rdata_q   <= 32'd0;
      ls_rdata_q   <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_owner_q <= resp_owner_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural BRAM, expected read data queued at
// issue time and matched against each rvalid pulse.
module tb_bram_port_arbiter;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rstn;
  logic              if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0]       if_addr, if_rdata;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]        ls_wstrb;
  logic [31:0]       ls_addr, ls_wdata, ls_rdata;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata = 32'd0;
  logic              stall_if, stall_ls;

  int checks = 0;
  int errors = 0;
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .stall_if(stall_if), .stall_ls(stall_ls)
  );

  // Behavioural single-port BRAM, read-first, 1-cycle latency.
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rdata <= mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    end
  end

  // Scoreboard: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (if_rvalid === 1'b1) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_rvalid_unexpected: got rdata %h, required no response", if_rdata);
        end else begin
          logic [31:0] e;
          e = if_q.pop_front();
          if (if_rdata !== e) begin
            errors++;
            $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
          end
        end
      end
      if (ls_rvalid === 1'b1) begin
        checks++;
        if (ls_q.size() == 0) begin
          errors++;
          $display("FAIL ls_rvalid_unexpected: got rdata %h, required no response", ls_rdata);
        end else begin
          logic [31:0] e;
          e = ls_q.pop_front();
          if (ls_rdata !== e) begin
            errors++;
            $display("FAIL ls_rdata: got %h, required %h", ls_rdata, e);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; if_flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_wstrb = 4'h0;
    if_addr = 32'h10; ls_addr = 32'h20; ls_wdata = 32'h0; if_flush = 1'b0;
    cyc(); cyc(); #3;
    checks++;
    if ({if_gnt, ls_gnt, bram_en, bram_we, if_rvalid, ls_rvalid} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt %b%b en %b we %h rv %b%b, required all 0",
               if_gnt, ls_gnt, bram_en, bram_we, if_rvalid, ls_rvalid);
    end
    checks++;
    if (if_rdata !== 32'd0 || ls_rdata !== 32'd0 || bram_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: got if %h ls %h addr %h, required 0", if_rdata, ls_rdata, bram_addr);
    end
    cyc();
    rstn = 1'b1; ls_req = 1'b0; if_addr = 32'h0000_0010;
    #3;
    checks++;
    if (if_gnt !== 1'b1 || bram_addr !== 14'd4 || bram_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch: got gnt %b addr %h, required 1 / 4", if_gnt, bram_addr);
    end
    if_q.push_back(32'd4);
    cyc(); idle(); #3;
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_fetch_rvalid: got %b, required 1", if_rvalid);
    end
    cyc();
  endtask

  task automatic test_if_stream();
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      #3;
      checks++;
      if (if_gnt !== 1'b1 || stall_if !== 1'b0) begin
        errors++;
        $display("FAIL stream_gnt%0d: got gnt %b stall %b, required 1 / 0", i, if_gnt, stall_if);
      end
      if (i > 0) begin
        checks++;
        if (if_rvalid !== 1'b1) begin
          errors++;
          $display("FAIL stream_rvalid%0d: got %b, required 1", i, if_rvalid);
        end
      end
      if_q.push_back(32'(i));
      cyc();
    end
    idle(); #3;
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL stream_last_rvalid: got %b, required 1", if_rvalid);
    end
    cyc(); #3;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL stream_pulse: got %b, required 0", if_rvalid);
    end
    cyc();
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    #3;
    checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || stall_if !== 1'b1 || stall_ls !== 1'b0) begin
      errors++;
      $display("FAIL coll_gnt: got ls %b if %b stall_if %b stall_ls %b, required 1 0 1 0",
               ls_gnt, if_gnt, stall_if, stall_ls);
    end
    checks++;
    if (bram_addr !== 14'h40 || bram_we !== 4'h0) begin
      errors++;
      $display("FAIL coll_addr: got addr %h we %h, required 40 / 0", bram_addr, bram_we);
    end
    ls_q.push_back(32'h40);
    cyc();
    ls_req = 1'b0; #3;
    checks++;
    if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL coll_resp: got ls_rv %b if_rv %b if_gnt %b, required 1 0 1", ls_rvalid, if_rvalid, if_gnt);
    end
    if_q.push_back(32'h80);
    cyc(); idle(); #3;
    checks++;
    if (if_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL coll_if_rvalid: got %b, required 1", if_rvalid);
    end
    cyc();
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    for (int c = 0; c < 10; c++) begin
      logic exp_if;
      exp_if = (c == 4) || (c == 9);
      #3;
      checks++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin
        errors++;
        $display("FAIL starve_cycle%0d: got if_gnt %b ls_gnt %b, required %b %b", c, if_gnt, ls_gnt, exp_if, !exp_if);
      end
      if (exp_if) if_q.push_back(32'h100);
      else        ls_q.push_back(32'hC0);
      cyc();
    end
    idle();
    cyc(); cyc();
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_we = 1'b1; ls_wstrb = 4'b0011; ls_wdata = 32'hAABBCCDD; ls_addr = 32'h20;
    #3;
    checks++;
    if (ls_gnt !== 1'b1 || bram_en !== 1'b1 || bram_we !== 4'b0011 ||
        bram_wdata !== 32'hAABBCCDD || bram_addr !== 14'd8) begin
      errors++;
      $display("FAIL store_drive: got gnt %b en %b we %b wd %h addr %h, required 1 1 0011 aabbccdd 8",
               ls_gnt, bram_en, bram_we, bram_wdata, bram_addr);
    end
    cyc();
    ls_we = 1'b1; ls_wstrb = 4'b0000; ls_wdata = 32'hFFFF_FFFF;
    #3;
    checks++;
    if (ls_rvalid !== 1'b0 || bram_en !== 1'b1 || bram_we !== 4'b0000) begin
      errors++;
      $display("FAIL store_zero_strb: got rv %b en %b we %b, required 0 1 0000", ls_rvalid, bram_en, bram_we);
    end
    cyc();
    ls_we = 1'b0;
    #3;
    checks++;
    if (ls_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL store_no_rvalid: got %b, required 0", ls_rvalid);
    end
    ls_q.push_back(32'h1122CCDD);
    cyc(); idle(); #3;
    checks++;
    if (ls_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL load_rvalid: got %b, required 1", ls_rvalid);
    end
    cyc(); #3;
    checks++;
    if (ls_rdata !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL load_hold: got %h, required 1122ccdd", ls_rdata);
    end
    cyc();
  endtask

  task automatic test_flush_and_reset();
    if_req = 1'b1; if_addr = 32'h4;
    if_q.push_back(32'd1);
    cyc();
    if_addr = 32'h40;
    cyc();
    if_req = 1'b0; if_flush = 1'b1; #3;
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'd1) begin
      errors++;
      $display("FAIL flush_resp: got rv %b rdata %h, required 0 / 1", if_rvalid, if_rdata);
    end
    cyc();
    if_req = 1'b1; if_addr = 32'h44; #3;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle_gnt: got %b, required 1", if_gnt);
    end
    cyc();
    if_req = 1'b0; if_flush = 1'b0; #3;
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'd1) begin
      errors++;
      $display("FAIL flush_at_grant: got rv %b rdata %h, required 0 / 1", if_rvalid, if_rdata);
    end
    cyc();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h30; if_addr = 32'h48;
    cyc();
    idle(); rstn = 1'b0; #3;
    checks++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || ls_rdata !== 32'd0) begin
      errors++;
      $display("FAIL midreset: got rv %b%b ls_rdata %h, required 0 0 0", if_rvalid, ls_rvalid, ls_rdata);
    end
    cyc();
    rstn = 1'b1;
    cyc(); #3;
    checks++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_rvalid: got %b%b, required 00", if_rvalid, ls_rvalid);
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'(i);
    mem[8] = 32'h11223344;
    test_reset();
    test_if_stream();
    test_collision();
    test_starvation();
    test_store_load();
    test_flush_and_reset();
    cyc(); cyc();
    checks++;
    if (if_q.size() != 0 || ls_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got pending if %0d ls %0d, required 0 0", if_q.size(), ls_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency unified BRAM between the IF1 fetch requester and the LS-stage load/store requester.
- Grants at most one access per cycle and returns read data one cycle after grant.
- Raises per-requester stall signals that the hazard unit folds into its pc/IF/LS stall and flush generation.
- LS has priority; a starvation counter guarantees forward progress for IF.

Parameters:
ADDR_W, 14, BRAM word-address width (byte address bits [ADDR_W+1:2] used)
STARVE_LIMIT, 4, consecutive IF denials after which IF wins one arbitration (1..15)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
if_req  input  1  IF read request
if_addr  input  32  IF byte address
if_flush  input  1  IF path flushed; discard any in-flight IF response
if_gnt  output  1  IF request accepted this cycle
if_rvalid  output  1  IF read data valid
if_rdata  output  32  IF read data, held until next if_rvalid
ls_req  input  1  LS request
ls_we  input  1  1 = store, 0 = load
ls_wstrb  input  4  store byte enables
ls_addr  input  32  LS byte address
ls_wdata  input  32  store data
ls_gnt  output  1  LS request accepted this cycle
ls_rvalid  output  1  LS load data valid
ls_rdata  output  32  LS load data, held until next ls_rvalid
bram_en  output  1  BRAM enable
bram_we  output  4  BRAM byte write enables
bram_addr  output  ADDR_W  BRAM word address
bram_wdata  output  32  BRAM write data
bram_rdata  input  32  BRAM read data (valid cycle after en)
stall_if  output  1  IF must hold (req && !gnt)
stall_ls  output  1  LS must hold (req && !gnt)

Behaviour:
- Reset (rstn low, asynchronous): starve_cnt=0, resp_owner=NONE, if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0. The combinational outputs gnt, stall and bram_* evaluate with all requests treated as 0: bram_en=0, bram_we=0, addr/wdata=0.
- Arbitration is combinational within the cycle:
  - ls_req only: LS granted.
  - if_req only: IF granted.
  - Both, with starve_cnt < STARVE_LIMIT: LS granted.
  - Both, with starve_cnt == STARVE_LIMIT: IF granted.
- BRAM drive:
  - The granted requester drives bram_en=1 and bram_addr=addr[ADDR_W+1:2].
  - An LS store drives bram_we=ls_wstrb and bram_wdata=ls_wdata.
  - All reads drive bram_we=0.
  - No grant: bram_en=0, bram_we=0.
- Store with ls_wstrb=0: granted, bram_en=1, no bytes written.
- Stores complete at grant; ls_rvalid is never raised for a store.
- starve_cnt update:
  - Cleared when IF is granted, or when if_req=0.
  - Incremented, saturating at STARVE_LIMIT, when if_req=1 and IF is denied.
- resp_owner register records the next-cycle response owner: IF read grant -> IF, LS load grant -> LS, otherwise NONE.
- Response cycle (cycle N+1 for a grant at cycle N):
  - Owner IF: if_rvalid=1 and if_rdata<=bram_rdata, unless if_flush was high in cycle N or N+1. In that case if_rvalid=0 and if_rdata is unchanged.
  - Owner LS: ls_rvalid=1 and ls_rdata<=bram_rdata. if_flush never affects LS.
  - rvalid is a single-cycle pulse. Read latency is exactly 1 cycle after grant, and back-to-back grants give back-to-back rvalids.
- if_flush in the same cycle as if_req: the grant still occurs (address fetched), but the response is suppressed.
- Addresses are not checked for alignment. Low 2 bits and bits above ADDR_W+1 are ignored; wrap-around is modulo 2^ADDR_W words.
- Reset asserted mid-transaction clears the pending response immediately; no rvalid follows reset release.
- stall_if = if_req && !if_gnt; stall_ls = ls_req && !ls_gnt; both combinational.

Test Plan:
- Reset: rstn=0 with if_req=ls_req=1 -> all gnt/rvalid/bram_en=0, rdata=0. Release rstn, IF fetch 0x0000_0010 -> bram_addr=4, if_rvalid at +1 with the BRAM word.
- IF-only stream of addresses 0x0,0x4,0x8 on consecutive cycles -> if_gnt every cycle, if_rvalid on 3 consecutive cycles with words 0,1,2, stall_if=0.
- Collision: if_req=1 steady plus an LS load to 0x100 -> ls_gnt=1, stall_if=1, bram_addr=0x40, ls_rvalid next cycle, if_rvalid=0 that cycle.
- Starvation, STARVE_LIMIT=4: ls_req and if_req held high -> LS granted 4 cycles, IF granted on the 5th, starve_cnt returns to 0, LS again on the 6th.
- Store then load: ls_we=1, wstrb=4'b0011, wdata=0xAABBCCDD at 0x20 over old 0x11223344, then a load from 0x20 -> ls_rvalid with 0x1122CCDD, no ls_rvalid for the store.
- Flush: IF granted at 0x40, if_flush=1 the next cycle -> if_rvalid=0, if_rdata keeps its prior value. Mid-response reset -> no rvalid after release.
